// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, committed direction, move tick, score and grow pulse; SNAKE_SPEEDUP_EN shortens the tick period on each score
module snake_game_ctrl #(
  parameter int TICK_DIV  = 12_500_000,
  parameter int MAX_SCORE = 99
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic       button,
  input  logic [3:0] direction,
  output logic [1:0] state,
  output logic [3:0] move_dir,
  output logic       move_tick,
  output logic [7:0] score,
  output logic       grow
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3;
  localparam logic [3:0] RIGHT = 4'b0001;
  logic [2:0] cur_q, prev_q;
  logic btn_rise, good_rise, bad_rise;
  logic [1:0] next_state;
  logic start, running, scored, wrap, dir_ok;
  logic [3:0] opposite;
  logic [3:0] pending;
  logic [23:0] cnt, period;
  assign {btn_rise, good_rise, bad_rise} = cur_q & ~prev_q;
  // register the levels then keep one more sample so rises act one cycle later
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= {button, goodColl, badColl};
      prev_q <= cur_q;
    end
  // game state register
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) state <= IDLE;
    else state <= next_state;
  // state transitions; a wall hit wins over a simultaneous button rise
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (btn_rise) next_state = RUN;
      RUN:   if (bad_rise) next_state = OVER; else if (btn_rise) next_state = PAUSE;
      PAUSE: if (btn_rise) next_state = RUN;
      OVER:  if (btn_rise) next_state = IDLE;
    endcase
  end
  // control strobes decoded from the current state and the rises
  always_comb begin
    start    = (state == IDLE) && btn_rise;
    running  = state == RUN;
    scored   = running && good_rise && !bad_rise;
    wrap     = running && (cnt >= period - 24'd1);
    opposite = {move_dir[2], move_dir[3], move_dir[0], move_dir[1]};
    dir_ok   = running && (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0)
               && (direction != move_dir) && (direction != opposite);
  end
  // move counter: runs in RUN, freezes in PAUSE, cleared otherwise
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      cnt       <= '0;
      move_tick <= 1'b0;
    end else begin
      move_tick <= wrap;
      cnt       <= running ? (wrap ? 24'd0 : cnt + 24'd1) : (state == PAUSE) ? cnt : 24'd0;
    end
  // reversal is judged against the committed direction so pending can never hold a U-turn
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      move_dir <= RIGHT;
      pending  <= RIGHT;
    end else if (start) begin
      move_dir <= RIGHT;
      pending  <= RIGHT;
    end else begin
      if (wrap) move_dir <= pending;
      if (dir_ok) pending <= direction;
    end
  // saturating score and grow pulse
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      score <= '0;
      grow  <= 1'b0;
    end else begin
      grow  <= scored;
      score <= start ? 8'd0 : (scored && score < 8'(MAX_SCORE)) ? score + 8'd1 : score;
    end
`ifdef SNAKE_SPEEDUP_EN
  logic [23:0] shrunk;
  assign shrunk = period - (period >> 3);
  // period shrinks by an eighth per food, floored at a quarter of the base
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) period <= 24'(TICK_DIV);
    else if (start) period <= 24'(TICK_DIV);
    else if (scored) period <= (shrunk < 24'(TICK_DIV >> 2)) ? 24'(TICK_DIV >> 2) : shrunk;
`else
  assign period = 24'(TICK_DIV);
`endif
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed game scenarios plus random play checked against a behavioural game model
module tb_snake_game_ctrl;
`ifdef SNAKE_SPEEDUP_EN
  localparam int TD = 64;
`else
  localparam int TD = 8;
`endif
  localparam int MS = 3;
  logic clk = 0, nRst = 0, goodColl = 0, badColl = 0, button = 0;
  logic [3:0] direction = 0;
  logic [1:0] state;
  logic [3:0] move_dir;
  logic move_tick, grow;
  logic [7:0] score;
  int n_checks = 0, n_fail = 0, grows = 0;
  int m_state, m_cnt, m_period, m_score;
  logic [3:0] m_dir, m_pend;
  bit m_tick, m_grow;
  logic [2:0] seen[$];

  snake_game_ctrl #(.TICK_DIV(TD), .MAX_SCORE(MS)) dut (
    .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl), .button(button),
    .direction(direction), .state(state), .move_dir(move_dir), .move_tick(move_tick),
    .score(score), .grow(grow)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] reverse_of(logic [3:0] d);
    case (d)
      4'b1000: return 4'b0100;
      4'b0100: return 4'b1000;
      4'b0010: return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_period = TD; m_score = 0;
    m_dir = 4'b0001; m_pend = 4'b0001; m_tick = 0; m_grow = 0;
    seen = '{3'b000, 3'b000};
  endtask

  // one clock of game rules; rises are seen one sample late (input sampled, then compared)
  task automatic model_edge();
    logic [2:0] r;
    bit run, scored, wrap, legal;
    int np;
    r = seen[1] & ~seen[0];
    run = m_state == 1;
    scored = run && r[1] && !r[0];
    wrap = run && (m_cnt >= m_period - 1);
    legal = run && $countones(direction) == 1 && direction != m_dir && direction != reverse_of(m_dir);
    seen.push_back({button, goodColl, badColl});
    void'(seen.pop_front());
    m_tick = wrap;
    m_grow = scored;
    if (wrap) m_dir = m_pend;
    if (legal) m_pend = direction;
    if (run) m_cnt = wrap ? 0 : m_cnt + 1;
    else if (m_state != 2) m_cnt = 0;
    if (scored) begin
      m_score = m_score < MS ? m_score + 1 : MS;
`ifdef SNAKE_SPEEDUP_EN
      np = m_period - m_period / 8;
      m_period = np < TD / 4 ? TD / 4 : np;
`endif
    end
    case (m_state)
      0: if (r[2]) begin m_state = 1; m_score = 0; m_dir = 4'b0001; m_pend = 4'b0001; m_cnt = 0; m_period = TD; end
      1: if (r[0]) m_state = 3; else if (r[2]) m_state = 2;
      2: if (r[2]) m_state = 1;
      default: if (r[2]) m_state = 0;
    endcase
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    if (grow) grows++;
    check("state", state, m_state);
    check("move_dir", move_dir, m_dir);
    check("move_tick", move_tick, m_tick);
    check("score", score, m_score);
    check("grow", grow, m_grow);
  endtask

  task automatic run_cycles(int n);
    repeat (n) cycle();
  endtask

  task automatic press();
    button = 1; cycle(); button = 0; cycle(); cycle();
  endtask

  task automatic check_reset(string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_dir"}, move_dir, 1);
    check({tag, "_tick"}, move_tick, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_grow"}, grow, 0);
  endtask

  task automatic wait_tick(string tag);
    int n = 0;
    while (!move_tick && n < 4 * TD) begin cycle(); n++; end
    check({tag, "_tick_seen"}, move_tick, 1);
  endtask

  initial begin
    int gap, ticks;
    model_reset();
    #12;
    check_reset("reset");
    nRst = 1;
    run_cycles(2);
    // start
    press();
    check("start_state", state, 1);
    check("start_score", score, 0);
    check("start_dir", move_dir, 4'b0001);
    wait_tick("first");
    gap = 0;
    do begin cycle(); gap++; end while (!move_tick && gap < 4 * TD);
    check("tick_gap", gap, TD);
    // turn: LEFT is a reversal of RIGHT, UP is legal
    direction = 4'b0010; cycle();
    direction = 4'b1000; cycle();
    direction = 4'b0000;
    wait_tick("turn");
    check("turn_dir", move_dir, 4'b1000);
    // pause freezes the counter
    run_cycles(3);
    press();
    check("paused", state, 2);
    ticks = 0;
    repeat (20) begin cycle(); if (move_tick) ticks++; end
    check("pause_ticks", ticks, 0);
    press();
    check("resumed", state, 1);
    // scoring: a held level counts once, then saturation
    grows = 0;
    goodColl = 1; run_cycles(4); goodColl = 0; run_cycles(2);
    check("score_held", score, 1);
    for (int k = 2; k <= 5; k++) begin
      goodColl = 1; cycle(); goodColl = 0; run_cycles(2);
      check("score_seq", score, k < MS ? k : MS);
    end
    check("grow_count", grows, 5);
    // simultaneous collisions: game over, no score
    goodColl = 1; badColl = 1; cycle(); goodColl = 0; badColl = 0; run_cycles(2);
    check("over_state", state, 3);
    check("over_score", score, MS);
    check("over_grow", grows, 5);
    press();
    check("idle_state", state, 0);
    check("idle_score", score, MS);
    press();
    check("restart_state", state, 1);
    check("restart_score", score, 0);
    // random play with occasional asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) button = ~button;
      if ($urandom_range(0, 7) == 0) goodColl = ~goodColl;
      if ($urandom_range(0, 39) == 0) badColl = ~badColl;
      if ($urandom_range(0, 3) == 0) direction = 4'($urandom_range(0, 15));
      cycle();
      if ($urandom_range(0, 299) == 0) begin
        #2 nRst = 0;
        model_reset();
        #1 check_reset("async_rst");
        #1 nRst = 1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-control stage fed by the input synchronizer stage. Takes the synchronized level signals `goodColl`, `badColl`, `button` and the one-hot `direction`, and derives five things from them:
- the game state machine;
- the committed movement direction, with U-turns rejected;
- the periodic move tick;
- the score;
- a grow pulse.

Its outputs drive the snake body/position logic and the display/score logic.

## Interface
Parameters:
- `TICK_DIV`, default 12_500_000: clk cycles between move ticks (base period); legal range 8..2^24-1.
- `MAX_SCORE`, default 99: score saturation value; must be below 256.

Ports:
- `clk`, input, 1: clock.
- `nRst`, input, 1: reset, asynchronous, active-low.
- `goodColl`, input, 1: synchronized food-collision level.
- `badColl`, input, 1: synchronized wall/self-collision level.
- `button`, input, 1: synchronized start/pause button level.
- `direction`, input, 4: synchronized one-hot request; [3]=UP, [2]=DOWN, [1]=LEFT, [0]=RIGHT.
- `state`, output, 2: game state; 0=IDLE, 1=RUN, 2=PAUSE, 3=OVER.
- `move_dir`, output, 4: committed one-hot direction.
- `move_tick`, output, 1: one-cycle pulse; the snake advances one cell.
- `score`, output, 8: food eaten this game.
- `grow`, output, 1: one-cycle pulse on a scored food collision.

## Operation
- **Edge detection:**
  - Internal previous-value flops for `button`, `goodColl` and `badColl`, each reset to 0.
  - Rise = current & ~previous.
  - Only rises act; held levels are ignored.
- **FSM:**
  - IDLE: button rise → RUN; on that transition clear `score`, set `move_dir`/pending to RIGHT and clear the tick counter.
  - RUN: badColl rise → OVER; else button rise → PAUSE. badColl has priority when both rise together.
  - PAUSE: button rise → RUN; collisions are ignored.
  - OVER: button rise → IDLE; `score` is held for display.
- **Direction:**
  - A request is valid only when all of these hold:
    - it is exactly one-hot;
    - the state is RUN;
    - it differs from `move_dir`;
    - it is not the opposite of `move_dir` (UP/DOWN, LEFT/RIGHT).
  - A valid request loads the pending register; the last valid request before a tick wins.
  - On `move_tick`: `move_dir` ← pending.
  - Reversal is checked against the committed `move_dir`, not pending. Two quick turns therefore cannot produce a U-turn within one tick.
  - Invalid, zero or multi-hot requests are ignored.
- **Tick counter:**
  - 24-bit counter, advances only in RUN.
  - Holds its value in PAUSE; cleared in IDLE and OVER.
  - When count == period-1: `move_tick`=1 and the counter wraps to 0.
- **Score:**
  - goodColl rise in RUN with no simultaneous badColl rise: `score` increments, saturating at MAX_SCORE, and `grow` pulses.
  - `grow` pulses even when `score` is saturated.
  - A goodColl rise in any other case has no effect.

## Timing
- **Reset values:** `state`=IDLE, `move_dir`=4'b0001, pending=4'b0001, `move_tick`=0, `score`=0, `grow`=0, counter=0.
- All outputs are registered.
- An input rise sampled at edge k (input 0 at edge k-1, 1 at edge k) shows its effect on outputs after edge k+1, i.e. one cycle of latency.
- **First tick:** after entering RUN, `move_tick` asserts for exactly one cycle after `period` RUN cycles, then repeats every `period` cycles.
- **PAUSE:** after PAUSE→RUN, the first tick arrives after the remaining count, not a full period.
- **Simultaneous events:**
  - A tick and a valid request in the same cycle: the tick commits the old pending value; the new request applies at the next tick.
  - `grow` and `move_tick` may coincide; both are asserted.
- **Asynchronous reset mid-game:** all state returns to reset values immediately; any in-flight pulse is dropped.

## Configuration
- Macro: `SNAKE_SPEEDUP_EN`.
- **Defined:** `period` is a register.
  - Loaded with TICK_DIV on IDLE→RUN.
  - On each scored goodColl: `period` ← `period` - (`period`>>3), floored at TICK_DIV>>2.
  - The new period takes effect at the next counter wrap; if the counter already exceeds period-1, wrap on the next cycle.
- **Undefined:** `period` is the constant TICK_DIV; the speed never changes.

## Test plan
All cases use TICK_DIV=8 and MAX_SCORE=3.
- **Reset, start, tick period:** reset, then one button rise. Expect `state`=1, `score`=0, `move_dir`=0001. The first `move_tick` comes 8 cycles later, then every 8 cycles.
- **Turn and reversal rejection:** in RUN moving RIGHT, apply `direction`=0010 (LEFT), then 1000 (UP). Only UP commits, at the next tick; LEFT is rejected.
- **Pause:** a button rise at count 5 → `state`=2. The counter holds and there is no tick for 20 cycles. A button rise → RUN; the tick comes after the remaining 2 counts.
- **Scoring and saturation:** five goodColl rises in RUN → `score` 1,2,3,3,3 and five `grow` pulses. A held level gives only one increment.
- **Simultaneous collisions and game over:** goodColl and badColl rise in the same cycle → `state`=3, `score` unchanged, no `grow`. A button rise → IDLE with `score` held; the next button rise clears it.
- **SNAKE_SPEEDUP_EN (when defined):** TICK_DIV=64 with four scores → periods 56, 49, 43, 38; further scores floor the period at 16.
